// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store size
// codes, FSM state encoding, response payload and small decode helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Unsigned size codes are load-only; 011/110/111 are never legal.
  function automatic logic funct3_bad(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

  // Force the lane offset to the natural alignment of the access size.
  function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 32-bit data memory word: extracts and extends
// load data, and merges store data into only the addressed byte lanes.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  byte_en;
  logic [31:0] store_rep;

  // Load path: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    byte_sel = mem_word[{lane, 3'b000} +: 8];
    half_sel = mem_word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = mem_word;
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = '0;
    endcase
  end

  // Store path: replicate the data across lanes and enable only the target bytes.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        store_rep = {4{store_data[7:0]}};
      end
      2'b01: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{store_data[15:0]}};
      end
      2'b10: begin
        byte_en   = 4'b1111;
        store_rep = store_data;
      end
      default: begin
        byte_en   = 4'b0000;
        store_rep = store_data;
      end
    endcase
    merged_word = mem_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = store_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a valid/ready request and
// response channel, programmable wait states and RV32I byte/half/word access.
// Optional macro DMEM_MISALIGN_ERR_EN: reject misaligned half/word accesses
// instead of silently aligning them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  rsp_t        rsp_q, rsp_d;

  logic          accept;
  logic          enter_resp;
  logic          mem_we;
  logic          cur_we;
  logic          cur_err;
  logic [2:0]    cur_f3;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [1:0]    cur_lane;
  logic [AW-1:0] cur_idx;
  logic [31:0]   mem_rword;
  logic [31:0]   ld_data;
  logic [31:0]   st_word;

  logic [31:0] mem [DEPTH_WORDS];

  // Operand select and error decode. With zero wait states the response is
  // formed on the accept edge itself, so the live request inputs are used
  // while IDLE and the captured copy otherwise.
  always_comb begin
    accept = (state_q == ST_IDLE) && req_valid;
    if (state_q == ST_IDLE) begin
      cur_we    = req_we;
      cur_f3    = req_funct3;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_f3    = f3_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_idx  = cur_addr[AW+1:2];
    cur_lane = align_lane(cur_f3, cur_addr[1:0]);
    cur_err  = funct3_bad(cur_we, cur_f3) ||
               ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_ERR_EN
    if ((cur_f3[1:0] == 2'b01) && cur_addr[0])           cur_err = 1'b1;
    if ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00)) cur_err = 1'b1;
`endif
    mem_rword = mem[cur_idx];
  end

  dmem_lane_align u_lane_align (
    .funct3      (cur_f3),
    .lane        (cur_lane),
    .mem_word    (mem_rword),
    .store_data  (cur_wdata),
    .load_data   (ld_data),
    .merged_word (st_word)
  );

  // Transaction FSM: accept, count wait states, hold response until consumed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_d      = rsp_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_STATES == 0) begin
            enter_resp = 1'b1;
            state_d    = ST_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          enter_resp = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rsp_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      rsp_d.err   = cur_err;
      rsp_d.rdata = (cur_err || cur_we) ? '0 : ld_data;
    end
    mem_we = enter_resp && cur_we && !cur_err;
  end

  // Control and captured-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_idx] <= st_word;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: per-cycle comparison against a
// transaction-level model, directed literal cases, and a second instance with
// three wait states for reset-during-wait behaviour.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        t_rst;
  logic        t_req_valid, t_req_ready, t_req_we;
  logic [2:0]  t_req_funct3;
  logic [31:0] t_req_addr, t_req_wdata;
  logic        t_rsp_valid, t_rsp_ready;
  logic [31:0] t_rsp_rdata;
  logic        t_rsp_err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(t_rst),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(t_req_we),
    .req_funct3(t_req_funct3), .req_addr(t_req_addr), .req_wdata(t_req_wdata),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
    .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    checks++;
    $display("FAIL %s: no handshake within 50 cycles", name);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mem_m [DEPTH];
  bit          m_busy, m_valid;
  int          m_left;
  logic        m_we;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_err;

  function automatic void model_exec();
    logic [31:0] a, w, v, mask;
    int sh;
    m_err = (m_f3 == 3'd3) || (m_f3 >= 3'd6) || (m_we && m_f3 >= 3'd4) ||
            ((m_addr >> 2) >= DEPTH);
`ifdef DMEM_MISALIGN_ERR_EN
    if ((m_f3 == 3'd1 || m_f3 == 3'd5) && m_addr[0]) m_err = 1'b1;
    if (m_f3 == 3'd2 && m_addr[1:0] != 2'b00) m_err = 1'b1;
`endif
    m_rdata = 32'h0;
    if (m_err) return;
    a = m_addr;
    if (m_f3 == 3'd1 || m_f3 == 3'd5) a = a & ~32'd1;
    if (m_f3 == 3'd2) a = a & ~32'd3;
    w  = mem_m[a >> 2];
    sh = int'(a % 4) * 8;
    if (!m_we) begin
      case (m_f3)
        3'd0: begin v = (w >> sh) & 32'hFF;   m_rdata = (v >= 32'h80)   ? (v | 32'hFFFFFF00) : v; end
        3'd1: begin v = (w >> sh) & 32'hFFFF; m_rdata = (v >= 32'h8000) ? (v | 32'hFFFF0000) : v; end
        3'd2: m_rdata = w;
        3'd4: m_rdata = (w >> sh) & 32'hFF;
        default: m_rdata = (w >> sh) & 32'hFFFF;
      endcase
    end else begin
      mask = (m_f3 == 3'd0) ? (32'hFF << sh) : (m_f3 == 3'd1) ? (32'hFFFF << sh) : 32'hFFFFFFFF;
      mem_m[a >> 2] = (w & ~mask) | ((m_wdata << sh) & mask);
    end
  endfunction

  // Compare DUT outputs with the model, then advance the model using the
  // inputs that the coming rising edge will sample.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
      end else begin
        chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
        if (m_valid) begin
          chk("rsp_rdata", rsp_rdata, m_rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
        end
        if (!m_busy) begin
          if (req_valid) begin
            m_we = req_we; m_f3 = req_funct3; m_addr = req_addr; m_wdata = req_wdata;
            m_busy = 1'b1;
            m_left = int'(WS);
            if (m_left == 0) begin model_exec(); m_valid = 1'b1; end
          end
        end else if (!m_valid) begin
          m_left--;
          if (m_left == 0) begin model_exec(); m_valid = 1'b1; end
        end else if (rsp_ready) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
      end
    end
  end

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd = '0; er = 1'b0; lat = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin tmo("accept"); req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin tmo("response"); return; end
    rd = rsp_rdata; er = rsp_err;
    repeat (stall) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic t3_xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
    rd = '0; er = 1'b0; lat = 0;
    t_req_valid = 1'b1; t_req_we = we; t_req_funct3 = f3; t_req_addr = addr; t_req_wdata = wd;
    if (!t_req_ready) begin tmo("t3_accept"); t_req_valid = 1'b0; return; end
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    lat = 1;
    while (!t_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!t_rsp_valid) begin tmo("t3_response"); return; end
    rd = t_rsp_rdata; er = t_rsp_err;
    t_rsp_ready = 1'b1;
    @(posedge clk); #1;
    t_rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          seen;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    t_rst = 1'b1; t_req_valid = 1'b0; t_req_we = 1'b0; t_req_funct3 = '0;
    t_req_addr = '0; t_req_wdata = '0; t_rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst = 1'b0; t_rst = 1'b0;
    #2;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Bring the working window (words 0..15) to a known state.
    for (int i = 0; i < 16; i++) xact(1'b1, 3'd2, 32'(i * 4), 32'h0, 0, rd, er, lat);

    // Store then load a word; latency pinned at 1+WAIT_STATES.
    xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", {31'b0, er}, 32'd0);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'b0, er}, 32'd0);
    chk("lw_latency", 32'(lat), 32'd2);

    // Byte store merged over zero; sign/zero extension.
    xact(1'b1, 3'd2, 32'h10, 32'h0, 0, rd, er, lat);
    xact(1'b1, 3'd0, 32'h13, 32'h00000080, 0, rd, er, lat);
    xact(1'b0, 3'd0, 32'h13, 32'h0, 0, rd, er, lat);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    xact(1'b0, 3'd4, 32'h13, 32'h0, 0, rd, er, lat);
    chk("lbu_rdata", rd, 32'h00000080);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er, lat);
    chk("lw_after_sb", rd, 32'h80000000);

    // Misaligned halfword load.
    xact(1'b1, 3'd2, 32'h10, 32'h1234F678, 0, rd, er, lat);
    xact(1'b0, 3'd1, 32'h11, 32'h0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    chk("lh_mis_err", {31'b0, er}, 32'd1);
    chk("lh_mis_rdata", rd, 32'h0);
`else
    chk("lh_mis_err", {31'b0, er}, 32'd0);
    chk("lh_mis_rdata", rd, 32'hFFFFF678);
`endif

    // Response held for five cycles of back-pressure.
    xact(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er, lat);
    chk("stall_rdata", rd, 32'h1234F678);

    // Error cases.
    xact(1'b0, 3'd3, 32'h10, 32'h0, 0, rd, er, lat);
    chk("f3_011_err", {31'b0, er}, 32'd1);
    chk("f3_011_rdata", rd, 32'h0);
    xact(1'b0, 3'd2, 32'h00001000, 32'h0, 0, rd, er, lat);
    chk("range_err", {31'b0, er}, 32'd1);
    chk("range_rdata", rd, 32'h0);
    xact(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 0, rd, er, lat);
    chk("store_f3_100_err", {31'b0, er}, 32'd1);
    xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er, lat);
    chk("errored_store_no_write", rd, 32'h1234F678);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'h00001000 | $urandom;
      else a = 32'($urandom_range(0, 63));
      xact(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
           int'($urandom_range(0, 3)), rd, er, lat);
    end

    // Reset during WAIT on the three-wait-state instance.
    t3_xact(1'b1, 3'd2, 32'h20, 32'h11111111, rd, er, lat);
    chk("t3_latency", 32'(lat), 32'd4);
    t_req_valid = 1'b1; t_req_we = 1'b1; t_req_funct3 = 3'd2;
    t_req_addr = 32'h20; t_req_wdata = 32'h22222222;
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    @(posedge clk); #1;
    t_rst = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen |= t_rsp_valid; end
    t_rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= t_rsp_valid; end
    chk("t3_no_rsp_after_reset", {31'b0, seen}, 32'd0);
    t3_xact(1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
    chk("t3_old_data", rd, 32'h11111111);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles between accept and response (0..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts request this cycle.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_funct3  input  3  RV32I size/sign code.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator consumes response.
REQ-013 SHALL have port rsp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request rejected (bad funct3, range, misalignment).

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly when WAIT_STATES=0.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-017 SHALL register req_we, req_funct3, req_addr, req_wdata on acceptance; later input changes ignored.
REQ-018 SHALL count WAIT_STATES cycles in WAIT with a down-counter, then enter RESP.
REQ-019 SHALL assert rsp_valid exactly 1+WAIT_STATES cycles after the accept edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready=1, then return to IDLE next edge.
REQ-021 SHALL NOT accept a new request in the cycle a response is consumed (minimum 1 idle cycle between transactions).
REQ-022 SHALL decode funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; 011/110/111 and stores with 100/101 -> rsp_err=1.
REQ-023 SHALL flag rsp_err=1 when req_addr[31:2] >= DEPTH_WORDS.
REQ-024 SHALL sample read data and commit store byte lanes on the edge entering RESP; errored stores write nothing.
REQ-025 SHALL sign-extend LB/LH, zero-extend LBU/LHU, select lane by addr[1:0].
REQ-026 SHALL merge SB/SH into only the addressed bytes; other bytes unchanged.

Reset
REQ-027 SHALL, on reset, force IDLE, req_ready=1 after deassertion, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-028 SHALL discard an accepted-but-uncommitted store when reset asserts in WAIT; storage contents are not cleared.

Configuration
REQ-029 SHALL honour macro DMEM_MISALIGN_ERR_EN: defined -> halfword at addr[0]=1 or word at addr[1:0]!=0 gives rsp_err=1, no write.
REQ-030 SHALL, without DMEM_MISALIGN_ERR_EN, force addr low bits to natural alignment (clear addr[0] for half, addr[1:0] for word) and complete normally.

Structure
REQ-031 SHALL place funct3 constants, FSM state enum and response struct in shared package dmem_pkg.
REQ-032 SHALL isolate lane extract/extend and store-merge in combinational sub-module dmem_lane_align.

Verification
REQ-033 SW 0xDEADBEEF @0x10, then LW @0x10, WAIT_STATES=1 -> rsp_valid 2 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-034 SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-035 LH @0x11 with DMEM_MISALIGN_ERR_EN -> err 1, rdata 0; without -> reads halfword @0x10, err 0.
REQ-036 rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready 0 throughout; one idle cycle after consume.
REQ-037 funct3=011 load, and LW @0x00001000 with DEPTH_WORDS=1024 -> err 1, rdata 0.
REQ-038 SW accepted then reset asserted in WAIT (WAIT_STATES=3) -> rsp_valid never asserts, later LW shows old data.
